// File: rtl/jfpjc_pkg.sv
// Shared constants and state encoding for the JPEG byte stuffer.
package jfpjc_pkg;

    typedef enum logic [2:0] {
        IDLE,
        EMIT,
        STUFF,
        EOI_FF,
        EOI_D9
    } stuffer_state_e;

    localparam logic [7:0] JPEG_STUFF_BYTE    = 8'h00;
    localparam logic [7:0] JPEG_MARKER_PREFIX = 8'hFF;
    localparam logic [7:0] JPEG_EOI           = 8'hD9;

    // Byte 0 is the MSB byte, which leads the stream.
    function automatic logic [7:0] word_byte(input logic [31:0] w, input logic [1:0] idx);
        logic [7:0] b;
        case (idx)
            2'd0:    b = w[31:24];
            2'd1:    b = w[23:16];
            2'd2:    b = w[15:8];
            default: b = w[7:0];
        endcase
        return b;
    endfunction

endpackage

// File: rtl/jpeg_byte_stuffer_word_fifo.sv
// DEPTH x 32 synchronous word FIFO; a push into a full FIFO without a
// same-cycle pop is dropped and latched into the sticky overflow flag.
module word_fifo #(
    parameter int DEPTH = 4,
    parameter int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clock,
    input  logic             nreset,
    input  logic             push,
    input  logic [31:0]      push_data,
    input  logic             pop,
    output logic [31:0]      pop_data,
    output logic             empty,
    output logic [CNT_W-1:0] count,
    output logic             overflow
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [31:0]      mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             full;
    logic             push_ok;
    logic             pop_ok;

    assign empty    = (count == '0);
    assign full     = (count == CNT_W'(DEPTH));
    assign pop_ok   = pop && !empty;
    // A full FIFO still takes a word when the head leaves in the same cycle.
    assign push_ok  = push && (!full || pop_ok);
    assign pop_data = mem[rd_ptr];

    always_ff @(posedge clock) begin
        if (push_ok) mem[wr_ptr] <= push_data;
    end

    always_ff @(posedge clock or negedge nreset) begin
        if (!nreset) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + 1'b1;
            if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
            case ({push_ok, pop_ok})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            if (push && !push_ok) overflow <= 1'b1;
        end
    end

endmodule

// File: rtl/jpeg_byte_stuffer.sv
// Serializes packed 32-bit words MSB byte first onto a valid/ready byte
// stream, inserting 0x00 after each 0xFF data byte and appending EOI on request.
module jpeg_byte_stuffer
    import jfpjc_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clock,
    input  logic             nreset,
    input  logic             word_in_valid,
    input  logic [31:0]      word_in,
    input  logic             eoi_request,
    output logic             byte_out_valid,
    input  logic             byte_out_ready,
    output logic [7:0]       byte_out,
    output logic             eoi_done,
    output logic [CNT_W-1:0] fifo_count,
    output logic             overflow
);

    stuffer_state_e state, state_d;
    logic [31:0]    word_q, word_d;
    logic [1:0]     idx, idx_d;
    logic           eoi_pending;
    logic           pend_clr;
    logic           done_d;
    logic           pop;
    logic [31:0]    pop_data;
    logic           fifo_empty;
    logic           xfer;
    logic           advance;
    logic [7:0]     cur_byte;

    word_fifo #(.DEPTH(DEPTH), .CNT_W(CNT_W)) u_fifo (
        .clock     (clock),
        .nreset    (nreset),
        .push      (word_in_valid),
        .push_data (word_in),
        .pop       (pop),
        .pop_data  (pop_data),
        .empty     (fifo_empty),
        .count     (fifo_count),
        .overflow  (overflow)
    );

    assign cur_byte       = word_byte(word_q, idx);
    assign byte_out_valid = (state != IDLE);
    assign xfer           = byte_out_valid && byte_out_ready;

    // Output is a pure function of registered state, so it holds while stalled.
    always_comb begin
        byte_out = 8'h00;
        case (state)
            EMIT:    byte_out = cur_byte;
            STUFF:   byte_out = JPEG_STUFF_BYTE;
            EOI_FF:  byte_out = JPEG_MARKER_PREFIX;
            EOI_D9:  byte_out = JPEG_EOI;
            default: byte_out = 8'h00;
        endcase
    end

    always_comb begin
        state_d  = state;
        word_d   = word_q;
        idx_d    = idx;
        pop      = 1'b0;
        pend_clr = 1'b0;
        done_d   = 1'b0;
        advance  = 1'b0;
        case (state)
            IDLE: begin
                if (!fifo_empty) begin
                    pop     = 1'b1;
                    word_d  = pop_data;
                    idx_d   = 2'd0;
                    state_d = EMIT;
                end else if (eoi_pending) begin
                    state_d = EOI_FF;
                end
            end
            EMIT: begin
                if (xfer) begin
                    if (cur_byte == JPEG_MARKER_PREFIX) state_d = STUFF;
                    else                                advance = 1'b1;
                end
            end
            STUFF: begin
                if (xfer) advance = 1'b1;
            end
            EOI_FF: begin
                if (xfer) state_d = EOI_D9;
            end
            EOI_D9: begin
                if (xfer) begin
                    pend_clr = 1'b1;
                    done_d   = 1'b1;
                    state_d  = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // Word completion chains straight into the next word to avoid a bubble.
        if (advance) begin
            if (idx != 2'd3) begin
                idx_d   = idx + 2'd1;
                state_d = EMIT;
            end else if (!fifo_empty) begin
                pop     = 1'b1;
                word_d  = pop_data;
                idx_d   = 2'd0;
                state_d = EMIT;
            end else begin
                state_d = IDLE;
            end
        end
    end

    always_ff @(posedge clock or negedge nreset) begin
        if (!nreset) begin
            state       <= IDLE;
            word_q      <= '0;
            idx         <= '0;
            eoi_pending <= 1'b0;
            eoi_done    <= 1'b0;
        end else begin
            state    <= state_d;
            word_q   <= word_d;
            idx      <= idx_d;
            eoi_done <= done_d;
            if (pend_clr)         eoi_pending <= 1'b0;
            else if (eoi_request) eoi_pending <= 1'b1;
        end
    end

endmodule
